// File: rtl/lsu_bridge.sv
`default_nettype none
// ============================================================================
// Module   : lsu_bridge
// Purpose  : Load/store unit between the execute stage and a req/ack data
//            memory port. Misaligned accesses that cross an NB-byte boundary
//            are split into two aligned beats; loads are extended in here.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_bridge #(
    parameter int XLEN             = 32,
    parameter int ADDR_W           = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic                clk_btn,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                rsp_valid,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic                rsp_err,
    output logic                mem_req,
    input  logic                mem_ack,
    output logic [ADDR_W-1:0]   addr_to_mem,
    output logic [XLEN/8-1:0]   be,
    output logic                mem_wen,
    output logic [XLEN-1:0]     data_to_mem,
    input  logic [XLEN-1:0]     data_from_mem
);

    localparam int NB = XLEN / 8;
    localparam int OB = $clog2(NB);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC1 = 2'd1;
    localparam logic [1:0] S_ACC2 = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]          state_q, state_d;
    logic                wen_q, uns_q, err_q, cross_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          size_q;
    logic [XLEN-1:0]     wdata_q;
    logic [2*XLEN-1:0]   rbuf_q;

    // Request-side classification, evaluated on the incoming fields
    logic [OB-1:0]       off_in;
    logic [3:0]          n_in;
    logic [4:0]          end_in;
    logic                cross_in, err_in, accept;

    assign off_in   = req_addr[OB-1:0];
    assign n_in     = 4'd1 << req_size;
    assign end_in   = 5'(off_in) + 5'(n_in);
    assign cross_in = end_in > 5'(NB);
    assign err_in   = (n_in > 4'(NB)) || (cross_in && !ALLOW_MISALIGNED);
    assign accept   = req_valid && (state_q == S_IDLE);

    // Quantities derived from the registered request
    logic [OB-1:0]       off_q;
    logic [3:0]          n_q;
    logic [ADDR_W-1:0]   beat1_addr, beat2_addr;
    logic [2*NB-1:0]     ones_w, mask_w;
    logic [2*XLEN-1:0]   wide_w;
    logic [XLEN-1:0]     sh_w, ld_w;
    logic                sgn_w;

    assign off_q      = addr_q[OB-1:0];
    assign n_q        = 4'd1 << size_q;
    assign beat1_addr = {addr_q[ADDR_W-1:OB], {OB{1'b0}}};
    assign beat2_addr = beat1_addr + ADDR_W'(NB);
    assign mask_w     = ones_w << off_q;
    assign wide_w     = {{XLEN{1'b0}}, wdata_q} << {off_q, 3'b000};
    assign sh_w       = XLEN'(rbuf_q >> {off_q, 3'b000});

    // Byte-enable seed and load extension: keep n bytes, fill the rest with sign or zero
    always_comb begin
        ones_w = '0;
        ld_w   = '0;
        sgn_w  = 1'b0;
        for (int i = 0; i < 2 * NB; i++) begin
            ones_w[i] = (i < int'(n_q));
        end
        for (int i = 0; i < NB; i++) begin
            if (i == int'(n_q) - 1) begin
                sgn_w = sh_w[8*i+7];
            end
        end
        for (int i = 0; i < NB; i++) begin
            ld_w[8*i +: 8] = (i < int'(n_q)) ? sh_w[8*i +: 8] : {8{sgn_w & ~uns_q}};
        end
    end

    // State register
    always_ff @(posedge clk_btn or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_valid) state_d = err_in ? S_RESP : S_ACC1;
            S_ACC1: if (mem_ack)   state_d = cross_q ? S_ACC2 : S_RESP;
            S_ACC2: if (mem_ack)   state_d = S_RESP;
            S_RESP:                state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    // Request capture at acceptance and read-beat capture on each ack
    always_ff @(posedge clk_btn or posedge rst) begin
        if (rst) begin
            wen_q   <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            cross_q <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            rbuf_q  <= '0;
        end else if (accept) begin
            wen_q   <= req_wen;
            uns_q   <= req_unsigned;
            err_q   <= err_in;
            cross_q <= cross_in;
            addr_q  <= req_addr;
            size_q  <= req_size;
            wdata_q <= req_wdata;
            rbuf_q  <= '0;
        end else if (mem_ack && state_q == S_ACC1) begin
            rbuf_q[XLEN-1:0] <= data_from_mem;
        end else if (mem_ack && state_q == S_ACC2) begin
            rbuf_q[2*XLEN-1:XLEN] <= data_from_mem;
        end
    end

    // Outputs decoded from state; bus outputs are zero outside a beat
    always_comb begin
        req_ready   = (state_q == S_IDLE);
        rsp_valid   = 1'b0;
        rsp_err     = 1'b0;
        rsp_rdata   = '0;
        mem_req     = 1'b0;
        mem_wen     = 1'b0;
        addr_to_mem = '0;
        be          = '0;
        data_to_mem = '0;
        case (state_q)
            S_ACC1: begin
                mem_req     = 1'b1;
                mem_wen     = wen_q;
                addr_to_mem = beat1_addr;
                be          = mask_w[NB-1:0];
                data_to_mem = wen_q ? wide_w[XLEN-1:0] : '0;
            end
            S_ACC2: begin
                mem_req     = 1'b1;
                mem_wen     = wen_q;
                addr_to_mem = beat2_addr;
                be          = mask_w[2*NB-1:NB];
                data_to_mem = wen_q ? wide_w[2*XLEN-1:XLEN] : '0;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = (err_q || wen_q) ? '0 : ld_w;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_bridge
// Purpose  : Directed self-checking bench for lsu_bridge (XLEN=32), with a
//            second instance built with misaligned accesses disallowed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_bridge;

    logic        clk_btn = 1'b0;
    logic        rst;
    logic        req_valid, na_valid;
    logic        req_wen, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        mem_ack;
    logic [31:0] data_from_mem;

    logic        req_ready, rsp_valid, rsp_err, mem_req, mem_wen;
    logic [31:0] rsp_rdata, addr_to_mem, data_to_mem;
    logic [3:0]  be;

    logic        na_ready, na_rsp_valid, na_rsp_err, na_mem_req, na_mem_wen;
    logic [31:0] na_rsp_rdata, na_addr, na_wdata_out;
    logic [3:0]  na_be;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_rd_q[$];
    logic        exp_err_q[$];

    always #5 clk_btn = ~clk_btn;

    lsu_bridge #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) u_dut (
        .clk_btn(clk_btn), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_req(mem_req), .mem_ack(mem_ack),
        .addr_to_mem(addr_to_mem), .be(be), .mem_wen(mem_wen),
        .data_to_mem(data_to_mem), .data_from_mem(data_from_mem)
    );

    lsu_bridge #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) u_dut_na (
        .clk_btn(clk_btn), .rst(rst),
        .req_valid(na_valid), .req_ready(na_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .rsp_valid(na_rsp_valid), .rsp_rdata(na_rsp_rdata),
        .rsp_err(na_rsp_err), .mem_req(na_mem_req), .mem_ack(mem_ack),
        .addr_to_mem(na_addr), .be(na_be), .mem_wen(na_mem_wen),
        .data_to_mem(na_wdata_out), .data_from_mem(data_from_mem)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_rsp(input logic [31:0] rd, input logic err);
        exp_rd_q.push_back(rd);
        exp_err_q.push_back(err);
    endtask

    task automatic step();
        @(posedge clk_btn);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk_btn);
    endtask

    // Scoreboard: every response pulse of the main instance is matched in order
    always @(negedge clk_btn) begin
        if (!rst && rsp_valid) begin
            checks++;
            assert (exp_rd_q.size() > 0) else begin
                errors++;
                $error("FAIL rsp_unexpected: observed=rsp_valid expected=no response");
            end
            if (exp_rd_q.size() > 0) begin
                chk("rsp_rdata", rsp_rdata, exp_rd_q.pop_front());
                chk("rsp_err", rsp_err, exp_err_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; na_valid = 1'b0; req_wen = 1'b0;
        req_addr = '0; req_size = '0; req_unsigned = 1'b0; req_wdata = '0;
        mem_ack = 1'b0; data_from_mem = '0;
        repeat (2) @(posedge clk_btn);

        // Reset values
        at_neg();
        chk("rst_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_be", be, 0);
        chk("rst_addr", addr_to_mem, 0);
        chk("rst_wdata", data_to_mem, 0);

        // Aligned word load issued in the first cycle after reset release
        step(); rst = 1'b0;
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h100; req_size = 2'd2;
        mem_ack = 1'b1; data_from_mem = 32'hDEADBEEF;
        expect_rsp(32'hDEADBEEF, 1'b0);
        at_neg(); chk("lw_ready", req_ready, 1);
        step(); req_valid = 1'b0;
        at_neg();
        chk("lw_mem_req", mem_req, 1);
        chk("lw_addr", addr_to_mem, 32'h100);
        chk("lw_be", be, 4'b1111);
        chk("lw_mem_wen", mem_wen, 0);
        chk("lw_no_early_rsp", rsp_valid, 0);
        step(); at_neg();
        chk("lw_rsp_t2", rsp_valid, 1);
        chk("lw_resp_not_ready", req_ready, 0);
        step();

        // Byte load at 0x103, signed then unsigned; second request waits through RESP
        req_valid = 1'b1; req_addr = 32'h103; req_size = 2'd0; req_unsigned = 1'b0;
        data_from_mem = 32'h80123456;
        expect_rsp(32'hFFFFFF80, 1'b0);
        step(); req_unsigned = 1'b1;
        expect_rsp(32'h00000080, 1'b0);
        at_neg();
        chk("lb_be", be, 4'b1000);
        chk("lb_addr", addr_to_mem, 32'h100);
        step(); at_neg();
        chk("lb_rsp", rsp_valid, 1);
        chk("lb_resp_not_ready", req_ready, 0);
        step(); at_neg();
        chk("lbu_not_taken_in_resp", mem_req, 0);
        chk("lbu_idle_ready", req_ready, 1);
        step(); req_valid = 1'b0; req_unsigned = 1'b0;
        at_neg(); chk("lbu_beat", mem_req, 1);
        step(); at_neg(); chk("lbu_rsp", rsp_valid, 1);
        step();

        // Split store at 0x102
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h102; req_size = 2'd2;
        req_wdata = 32'h11223344;
        expect_rsp(32'h0, 1'b0);
        step(); req_valid = 1'b0;
        at_neg();
        chk("sw_b1_addr", addr_to_mem, 32'h100);
        chk("sw_b1_be", be, 4'b1100);
        chk("sw_b1_data", data_to_mem, 32'h33440000);
        chk("sw_b1_wen", mem_wen, 1);
        step(); at_neg();
        chk("sw_b2_addr", addr_to_mem, 32'h104);
        chk("sw_b2_be", be, 4'b0011);
        chk("sw_b2_data", data_to_mem, 32'h00001122);
        chk("sw_b2_no_rsp", rsp_valid, 0);
        step(); at_neg();
        chk("sw_rsp_t3", rsp_valid, 1);
        chk("sw_resp_wen", mem_wen, 0);
        chk("sw_resp_memreq", mem_req, 0);
        step();

        // Split load at 0x103 with three wait states per beat
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h103; req_size = 2'd2;
        mem_ack = 1'b0; data_from_mem = 32'hFFFFFFFF;
        expect_rsp(32'h223344AA, 1'b0);
        step(); req_valid = 1'b0;
        at_neg();
        chk("lws_b1_addr", addr_to_mem, 32'h100);
        chk("lws_b1_be", be, 4'b1000);
        step(); step(); at_neg();
        chk("lws_b1_hold_addr", addr_to_mem, 32'h100);
        chk("lws_b1_hold_be", be, 4'b1000);
        chk("lws_b1_hold_req", mem_req, 1);
        step(); mem_ack = 1'b1; data_from_mem = 32'hAABBCCDD;
        at_neg(); chk("lws_b1_ack_addr", addr_to_mem, 32'h100);
        step(); mem_ack = 1'b0; data_from_mem = 32'hFFFFFFFF;
        at_neg();
        chk("lws_b2_addr", addr_to_mem, 32'h104);
        chk("lws_b2_be", be, 4'b0111);
        step(); step(); at_neg();
        chk("lws_b2_hold_addr", addr_to_mem, 32'h104);
        chk("lws_b2_hold_be", be, 4'b0111);
        chk("lws_no_early_rsp", rsp_valid, 0);
        step(); mem_ack = 1'b1; data_from_mem = 32'h11223344;
        step(); mem_ack = 1'b0;
        at_neg(); chk("lws_rsp", rsp_valid, 1);
        step();

        // Dword access on a 32-bit bridge is rejected without any bus beat
        req_valid = 1'b1; req_addr = 32'h100; req_size = 2'd3; mem_ack = 1'b1;
        expect_rsp(32'h0, 1'b1);
        step(); req_valid = 1'b0;
        at_neg();
        chk("ld_err_rsp_t1", rsp_valid, 1);
        chk("ld_err_flag", rsp_err, 1);
        chk("ld_err_no_bus", mem_req, 0);
        step(); at_neg();
        chk("ld_err_done", rsp_valid, 0);
        chk("ld_err_still_no_bus", mem_req, 0);
        step();

        // Misaligned-disallowed instance: crossing half and word loads are errors
        na_valid = 1'b1; req_addr = 32'h103; req_size = 2'd1;
        step(); na_valid = 1'b0;
        at_neg();
        chk("na_lh_rsp", na_rsp_valid, 1);
        chk("na_lh_err", na_rsp_err, 1);
        chk("na_lh_rdata", na_rsp_rdata, 0);
        chk("na_lh_no_bus", na_mem_req, 0);
        step(); step();
        na_valid = 1'b1; req_addr = 32'h102; req_size = 2'd2;
        step(); na_valid = 1'b0;
        at_neg();
        chk("na_lw_err", na_rsp_err, 1);
        chk("na_lw_no_bus", na_mem_req, 0);
        step(); step();
        na_valid = 1'b1; req_addr = 32'h104; req_size = 2'd2; data_from_mem = 32'h12345678;
        step(); na_valid = 1'b0;
        at_neg(); chk("na_aligned_beat", na_mem_req, 1);
        step(); at_neg();
        chk("na_aligned_rsp", na_rsp_valid, 1);
        chk("na_aligned_noerr", na_rsp_err, 0);
        chk("na_aligned_rdata", na_rsp_rdata, 32'h12345678);
        step();

        // Reset asserted during the second beat of a split load
        req_valid = 1'b1; req_addr = 32'h102; req_size = 2'd2; mem_ack = 1'b1;
        step(); req_valid = 1'b0;
        step(); mem_ack = 1'b0;
        at_neg();
        chk("rst_mid_in_acc2", mem_req, 1);
        chk("rst_mid_addr", addr_to_mem, 32'h104);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_memreq_drop", mem_req, 0);
        chk("rst_mid_ready", req_ready, 1);
        mem_ack = 1'b1;
        step(); step(); rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            at_neg();
            chk("rst_mid_no_rsp", rsp_valid, 0);
            chk("ack_ignored_idle", mem_req, 0);
        end
        mem_ack = 1'b0;
        chk("sb_drained", exp_rd_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
